// File: rtl/maze_game_ctrl.sv
// -----------------------------------------------------------------------------
// maze_game_ctrl
//
// Game controller for an 8x8 maze. A start pulse loads the level's start
// position and terminal cell. Each move pulse issues a wall lookup to an
// external map RAM. The move is then accepted or rejected based on the wall
// bit, which arrives one cycle after the request.
//
// Optional feature (macro MAZE_TIMEOUT_EN):
//   - Adds a per-game countdown timer: TIME_LIMIT seconds of TICK_DIV cycles.
//   - Expiry in PLAY or CHECK ends the game in LOSE.
//   - Without the macro, time_left is tied to 0 and LOSE is unreachable.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse: start/restart a game (any state)
//   level      in   map select, sampled with start
//   dir[3:0]   in   move pulses: [0] row+1, [1] row-1, [2] col-1, [3] col+1
//   map_rd_req out  one-cycle wall lookup request
//   map_rd_row out  lookup row (valid with map_rd_req)
//   map_rd_col out  lookup column (valid with map_rd_req)
//   map_wall   in   wall bit, valid the cycle after map_rd_req
//   pos_row    out  player row
//   pos_col    out  player column
//   step_cnt   out  accepted moves this game (saturating)
//   state      out  IDLE=0 PLAY=1 CHECK=2 WIN=3 LOSE=4
//   time_left  out  remaining seconds
//   done       out  one-cycle pulse on entry to WIN or LOSE
// -----------------------------------------------------------------------------
module maze_game_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned TIME_LIMIT = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       level,
  input  logic [3:0] dir,
  output logic       map_rd_req,
  output logic [2:0] map_rd_row,
  output logic [2:0] map_rd_col,
  input  logic       map_wall,
  output logic [2:0] pos_row,
  output logic [2:0] pos_col,
  output logic [7:0] step_cnt,
  output logic [2:0] state,
  output logic [7:0] time_left,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  // A zero-length tick, or a limit beyond the 8-bit counter, is not a usable
  // configuration. The empty scope marks such a build in the hierarchy.
  if (TICK_DIV == 0 || TIME_LIMIT > 255) begin : g_invalid_timer_config
  end

  state_e     state_q, state_d;
  logic [2:0] row_q, col_q;
  logic [2:0] term_row_q, term_col_q;
  logic [2:0] rd_row_q, rd_col_q;
  logic [7:0] steps_q;
  logic       rd_req_q, rd_req_d;
  logic       done_q, done_d;

  logic       mv_valid;
  logic [2:0] tgt_row, tgt_col;
  logic       sample, accept, win, expire;

  // Move decode: only the lowest-index set bit counts.
  // Off-grid targets are flagged invalid.
  always_comb begin
    mv_valid = 1'b0;
    tgt_row  = row_q;
    tgt_col  = col_q;
    if (dir[0]) begin
      mv_valid = (row_q != 3'd7);
      tgt_row  = row_q + 3'd1;
    end else if (dir[1]) begin
      mv_valid = (row_q != 3'd0);
      tgt_row  = row_q - 3'd1;
    end else if (dir[2]) begin
      mv_valid = (col_q != 3'd0);
      tgt_col  = col_q - 3'd1;
    end else if (dir[3]) begin
      mv_valid = (col_q != 3'd7);
      tgt_col  = col_q + 3'd1;
    end
  end

  // CHECK occupies two cycles. In the first, the request is on the bus.
  // In the second, the RAM answers and map_wall is sampled.
  assign sample = (state_q == S_CHECK) && !rd_req_q;
  assign accept = sample && !map_wall;
  assign win    = accept && (rd_row_q == term_row_q) && (rd_col_q == term_col_q);

`ifdef MAZE_TIMEOUT_EN
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [7:0]    time_q;
  logic          timing;
  logic          tick;

  assign timing = (state_q == S_PLAY) || (state_q == S_CHECK);
  assign tick   = timing && (presc_q == PRESC_MAX);
  // Expiry fires on the tick that takes the counter to zero.
  // It also fires if the counter already reads zero (TIME_LIMIT of 0).
  assign expire = timing && ((time_q == 8'd0) || (tick && time_q == 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= 8'd0;
    end else if (start) begin
      presc_q <= '0;
      time_q  <= 8'(TIME_LIMIT);
    end else if (timing) begin
      if (tick) begin
        presc_q <= '0;
        if (time_q != 8'd0) time_q <= time_q - 8'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Start overrides everything.
  // Timeout overrides a new move.
  // A win found in the same cycle as timeout still wins.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_PLAY;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (expire)        state_d = S_LOSE;
          else if (mv_valid) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (win)         state_d = S_WIN;
          else if (expire) state_d = S_LOSE;
          else if (sample) state_d = S_PLAY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign rd_req_d = !start && (state_q == S_PLAY) && !expire && mv_valid;
  assign done_d   = ((state_d == S_WIN) || (state_d == S_LOSE)) && (state_d != state_q);

  // Position, score and lookup registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      term_row_q <= 3'd0;
      term_col_q <= 3'd0;
      rd_row_q   <= 3'd0;
      rd_col_q   <= 3'd0;
      steps_q    <= 8'd0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_req_q <= rd_req_d;
      done_q   <= done_d;
      if (rd_req_d) begin
        rd_row_q <= tgt_row;
        rd_col_q <= tgt_col;
      end
      if (start) begin
        steps_q <= 8'd0;
        if (level) begin
          row_q      <= 3'd7;
          col_q      <= 3'd6;
          term_row_q <= 3'd1;
          term_col_q <= 3'd7;
        end else begin
          row_q      <= 3'd6;
          col_q      <= 3'd7;
          term_row_q <= 3'd0;
          term_col_q <= 3'd0;
        end
      end else if (accept) begin
        row_q <= rd_row_q;
        col_q <= rd_col_q;
        if (steps_q != 8'hFF) steps_q <= steps_q + 8'd1;
      end
    end
  end

  // Output assignments
  always_comb begin
    map_rd_req = rd_req_q;
    map_rd_row = rd_row_q;
    map_rd_col = rd_col_q;
    pos_row    = row_q;
    pos_col    = col_q;
    step_cnt   = steps_q;
    state      = state_q;
    done       = done_q;
`ifdef MAZE_TIMEOUT_EN
    time_left  = time_q;
`else
    time_left  = 8'd0;
`endif
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
`timescale 1ns/1ps
module tb_maze_game_ctrl;

`ifdef MAZE_TIMEOUT_EN
  localparam int unsigned TDIV = 4;
  localparam int unsigned TLIM = 2;
`else
  localparam int unsigned TDIV = 8;
  localparam int unsigned TLIM = 60;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       level;
  logic [3:0] dir;
  logic       map_rd_req;
  logic [2:0] map_rd_row, map_rd_col;
  logic       map_wall;
  logic [2:0] pos_row, pos_col;
  logic [7:0] step_cnt;
  logic [2:0] state;
  logic [7:0] time_left;
  logic       done;

  always #5 clk = ~clk;

  maze_game_ctrl #(.TICK_DIV(TDIV), .TIME_LIMIT(TLIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .level(level), .dir(dir),
    .map_rd_req(map_rd_req), .map_rd_row(map_rd_row), .map_rd_col(map_rd_col),
    .map_wall(map_wall), .pos_row(pos_row), .pos_col(pos_col),
    .step_cnt(step_cnt), .state(state), .time_left(time_left), .done(done)
  );

  typedef struct {
    bit         is_lookup;
    logic [2:0] st;
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] steps;
    bit         dn;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   wall [8][8];
  bit   init_done = 0;

  // Reference model of the game (abstract: position, goal, score, phase)
  int m_state = 0, m_row = 0, m_col = 0, m_steps = 0, m_trow = 0, m_tcol = 0;

  task automatic push_status(input int st, input bit dn);
    exp_t e;
    e.is_lookup = 0; e.st = 3'(st); e.row = 3'(m_row); e.col = 3'(m_col);
    e.steps = 8'(m_steps); e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic push_lookup(input int r, input int c);
    exp_t e;
    e.is_lookup = 1; e.st = 3'd0; e.row = 3'(r); e.col = 3'(c);
    e.steps = 8'd0; e.dn = 0;
    exp_q.push_back(e);
  endtask

  task automatic set_level(input bit lvl);
    if (lvl) begin m_row = 7; m_col = 6; m_trow = 1; m_tcol = 7; end
    else     begin m_row = 6; m_col = 7; m_trow = 0; m_tcol = 0; end
    m_steps = 0;
  endtask

  task automatic do_start(input bit lvl);
    @(negedge clk);
    start = 1'b1; level = lvl;
    set_level(lvl);
    if (m_state != 1) push_status(1, 0);
    m_state = 1;
    @(negedge clk);
    start = 1'b0; level = 1'($urandom);
  endtask

  // One move pulse. Accepted moves last four negedges:
  // PLAY, CHECK request, CHECK sample, back.
  // Optional noise on dir during CHECK must be ignored.
  task automatic do_move(input logic [3:0] d, input bit noise);
    int b = -1;
    int tr, tc;
    bit acc;
    for (int i = 0; i < 4; i++) if (d[i] && b < 0) b = i;
    tr = m_row; tc = m_col;
    case (b)
      0: tr = tr + 1;
      1: tr = tr - 1;
      2: tc = tc - 1;
      3: tc = tc + 1;
      default: ;
    endcase
    acc = (m_state == 1) && (b >= 0) && (tr >= 0) && (tr <= 7) && (tc >= 0) && (tc <= 7);
    @(negedge clk);
    dir = d;
    if (acc) begin
      push_status(2, 0);
      push_lookup(tr, tc);
      if (!wall[tr][tc]) begin
        m_row = tr; m_col = tc;
        if (m_steps < 255) m_steps = m_steps + 1;
      end
      if (!wall[tr][tc] && tr == m_trow && tc == m_tcol) begin
        m_state = 3;
        push_status(3, 1);
      end else begin
        push_status(1, 0);
      end
    end
    @(negedge clk);
    dir = (acc && noise) ? 4'($urandom) : 4'b0;
    if (acc) begin
      @(negedge clk);
      dir = noise ? 4'($urandom) : 4'b0;
      @(negedge clk);
      dir = 4'b0;
    end
  endtask

  // Start arriving during CHECK, either in the request phase (0)
  // or in the sample phase (1). It must reload the start cell.
  task automatic start_mid_check(input int phase);
    @(negedge clk);
    dir = 4'b0010;
    push_status(2, 0);
    push_lookup(5, 7);
    @(negedge clk);
    dir = 4'b0;
    if (phase == 1) @(negedge clk);
    start = 1'b1; level = 1'b0;
    set_level(0);
    m_state = 1;
    push_status(1, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_walls();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) wall[r][c] = 0;
  endtask

  // Map RAM stand-in: the answer appears the cycle after the request.
  // At other times map_wall carries random junk.
  initial begin
    bit pend = 0;
    logic [2:0] pr = 3'd0, pc = 3'd0;
    map_wall = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) map_wall = wall[pr][pc];
      else      map_wall = 1'($urandom);
      pend = map_rd_req; pr = map_rd_row; pc = map_rd_col;
    end
  end

  // Monitor: compares every state change and every lookup request
  // against the next queued expectation.
  initial begin
    logic [2:0] prev;
    exp_t e;
    wait (init_done);
    prev = state;
    forever begin
      @(negedge clk);
      if (state != prev) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_state_change got st=%0d pos=(%0d,%0d) required no change", state, pos_row, pos_col);
        end else begin
          e = exp_q.pop_front();
          if (e.is_lookup || state !== e.st || pos_row !== e.row || pos_col !== e.col ||
              step_cnt !== e.steps || done !== e.dn) begin
            err_cnt++;
            $display("FAIL status got st=%0d pos=(%0d,%0d) steps=%0d done=%0d required lookup=%0d st=%0d pos=(%0d,%0d) steps=%0d done=%0d",
                     state, pos_row, pos_col, step_cnt, done, e.is_lookup, e.st, e.row, e.col, e.steps, e.dn);
          end else begin
            $display("[%0t] status st=%0d pos=(%0d,%0d) steps=%0d done=%0d", $time, state, pos_row, pos_col, step_cnt, done);
          end
        end
      end else if (done) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL spurious_done got done=1 in st=%0d required 0", state);
      end
      if (map_rd_req) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_lookup got (%0d,%0d) required none", map_rd_row, map_rd_col);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_lookup || map_rd_row !== e.row || map_rd_col !== e.col) begin
            err_cnt++;
            $display("FAIL lookup got (%0d,%0d) required lookup=%0d (%0d,%0d)",
                     map_rd_row, map_rd_col, e.is_lookup, e.row, e.col);
          end else begin
            $display("[%0t] lookup (%0d,%0d)", $time, map_rd_row, map_rd_col);
          end
        end
      end
      prev = state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test required completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; level = 1'b0; dir = 4'b0;
    clear_walls();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (state !== 3'd0 || pos_row !== 3'd0 || pos_col !== 3'd0 || step_cnt !== 8'd0 ||
        map_rd_req !== 1'b0 || map_rd_row !== 3'd0 || map_rd_col !== 3'd0 ||
        done !== 1'b0 || time_left !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset got st=%0d pos=(%0d,%0d) steps=%0d req=%0d rd=(%0d,%0d) done=%0d time=%0d required all zero",
               state, pos_row, pos_col, step_cnt, map_rd_req, map_rd_row, map_rd_col, done, time_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    init_done = 1;

`ifdef MAZE_TIMEOUT_EN
    // No moves: LOSE must appear exactly 8 cycles after PLAY is entered.
    do_start(0);
    m_state = 4;
    push_status(4, 1);
    repeat (7) @(negedge clk);
    vec_cnt++;
    if (state !== 3'd1) begin
      err_cnt++;
      $display("FAIL timeout_early got st=%0d required 1", state);
    end
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if (state !== 3'd4 || time_left !== 8'd0) begin
        err_cnt++;
        $display("FAIL timeout_hold got st=%0d time=%0d required st=4 time=0", state, time_left);
      end
    end
`else
    do_start(0);                 // IDLE -> PLAY at (6,7)
    do_move(4'b0010, 0);         // lookup (5,7), accepted
    do_start(0);                 // restart in PLAY reloads (6,7)
    do_move(4'b1000, 0);         // col 8 is off grid: ignored
    do_move(4'b0011, 1);         // [0] wins priority: lookup (7,7)
    wall[6][7] = 1;
    do_move(4'b0010, 1);         // blocked by a wall
    wall[6][7] = 0;

    do_start(0);                 // walk to (0,0) for a win
    repeat (6) do_move(4'b0010, 0);
    repeat (7) do_move(4'b0100, 0);
    do_move(4'b0001, 0);         // ignored in WIN
    do_move(4'b1000, 0);

    do_start(0);
    start_mid_check(0);
    start_mid_check(1);

    // Reset during CHECK discards the pending answer
    @(negedge clk);
    dir = 4'b0010;
    push_status(2, 0);
    push_lookup(5, 7);
    @(negedge clk);
    dir = 4'b0;
    #1 rst_n = 1'b0;
    m_state = 0; m_row = 0; m_col = 0; m_steps = 0;
    push_status(0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bounce on level 1 until the step counter saturates
    do_start(1);
    for (int i = 0; i < 130; i++) begin
      do_move(4'b0010, 0);
      do_move(4'b0001, 0);
    end

    // Random play with random walls and occasional restarts
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 5) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            wall[r][c] = ($urandom_range(0, 99) < 25);
        do_start(1'($urandom_range(0, 1)));
      end else begin
        do_move(4'($urandom), 1'($urandom_range(0, 1)));
      end
    end
`endif

    repeat (5) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL pending_expectations got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
